seq_divider: RTL



---
 rtl/seq_divider.sv | 128 ++++++++++++
 1 files changed

// File: rtl/seq_divider.sv
// Iterative restoring divider: one quotient bit per clock, signed/unsigned,
// start/busy/done handshake with divide-by-zero detection.
module seq_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             DZ
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [WIDTH-1:0]  rem_q, rem_d;
  logic [WIDTH-1:0]  dq_q, dq_d;
  logic [WIDTH-1:0]  absb_q, absb_d;
  logic              negq_q, negq_d;
  logic              negr_q, negr_d;
  logic [WIDTH-1:0]  q_q, q_d;
  logic [WIDTH-1:0]  r_q, r_d;
  logic              dz_q, dz_d;

  logic [WIDTH-1:0]  abs_a, abs_b;
  logic [WIDTH:0]    shifted, trial;
  logic              qbit;
  logic [WIDTH-1:0]  rem_next, dq_next;

  always_comb begin
    abs_a    = (signed_op && A[WIDTH-1]) ? (~A + 1'b1) : A;
    abs_b    = (signed_op && B[WIDTH-1]) ? (~B + 1'b1) : B;
    // rem stays below |B|, so the 33-bit trial sign bit is the borrow
    shifted  = {rem_q, dq_q[WIDTH-1]};
    trial    = shifted - {1'b0, absb_q};
    qbit     = ~trial[WIDTH];
    rem_next = qbit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    dq_next  = {dq_q[WIDTH-2:0], qbit};

    state_d = state_q;
    count_d = count_q;
    rem_d   = rem_q;
    dq_d    = dq_q;
    absb_d  = absb_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    q_d     = q_q;
    r_d     = r_q;
    dz_d    = dz_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          negq_d = signed_op & (A[WIDTH-1] ^ B[WIDTH-1]);
          negr_d = signed_op & A[WIDTH-1];
          if (B == '0) begin
            q_d     = '1;
            r_d     = A;
            dz_d    = 1'b1;
            state_d = StDone;
          end else begin
            rem_d   = '0;
            dq_d    = abs_a;
            absb_d  = abs_b;
            count_d = '0;
            state_d = StRun;
          end
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        rem_d   = rem_next;
        dq_d    = dq_next;
        count_d = count_q + 1'b1;
        if (count_q == CntW'(WIDTH - 1)) begin
          q_d     = negq_q ? (~dq_next + 1'b1) : dq_next;
          r_d     = negr_q ? (~rem_next + 1'b1) : rem_next;
          dz_d    = 1'b0;
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      count_q <= '0;
      rem_q   <= '0;
      dq_q    <= '0;
      absb_q  <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rem_q   <= rem_d;
      dq_q    <= dq_d;
      absb_q  <= absb_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dz_q    <= dz_d;
    end
  end

  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);
  assign Q    = q_q;
  assign R    = r_q;
  assign DZ   = dz_q;

endmodule
